mlp_inference_engine: RTL and testbench
=======================================

// Module: mlp_inference_engine
// PURPOSE
//  Parametrised two-layer perceptron engine: for each of M datapoints (rows of A), computes H hidden neurons
//  from A and weight memory B, then one output neuron from the hidden values and weight memory C.
//  Each output is written to RES.
//  Sequencing is internal and serial: one MAC per cycle, one synchronous read port per memory. Any H, N, M fit.
//  Sits between the AXI-stream/BRAM loader (fills A/B/C) and the result streamer (drains RES).
// PARAMETERS
//  WIDTH          8   signed two's-complement data/weight width
//  FRAC_BITS      4   fractional bits of every operand and result (Q(WIDTH-FRAC_BITS).FRAC_BITS)
//  M             64   datapoints (rows of A)
//  N              7   features per datapoint (columns of A)
//  H              2   hidden neurons, >=1
//  HIDDEN_RELU    1   1: ReLU on hidden outputs; 0: identity
//  A_DEPTH_BITS   9   address bits of A (>= clog2(M*N))
//  B_DEPTH_BITS   4   address bits of B (>= clog2((N+1)*H))
//  C_DEPTH_BITS   2   address bits of C (>= clog2(H+1))
//  RES_DEPTH_BITS 6   address bits of RES (>= clog2(M))
// PORTS
//  clk                in   1               clock, all state on rising edge
//  rst                in   1               asynchronous, active-high reset
//  Start              in   1               1-cycle pulse; ignored unless idle
//  Done               out  1               1-cycle pulse after final RES write
//  Busy               out  1               high from cycle after accepted Start until Done
//  A_read_en/_address out  1/A_DEPTH_BITS  A[r][c] at r*N+c
//  A_read_data_out    in   WIDTH           data one cycle after address
//  B_read_en/_address out  1/B_DEPTH_BITS  B[k][j] at k*H+j; row k=0 is hidden bias
//  B_read_data_out    in   WIDTH           one-cycle latency
//  C_read_en/_address out  1/C_DEPTH_BITS  C[k] at k; k=0 is output bias
//  C_read_data_out    in   WIDTH           one-cycle latency
//  RES_write_en       out  1               write strobe, one cycle per datapoint
//  RES_write_address  out  RES_DEPTH_BITS  datapoint index r
//  RES_write_data_in  out  WIDTH           output neuron value for row r
// BEHAVIOUR
//  Reset (async, any time incl. mid-run): FSM->IDLE; row/neuron/k counters, accumulator, hidden regs cleared.
//    Done, Busy, all *_en, all addresses and RES_write_data_in 0. No Done for an aborted run. RES not written.
//  FSM: IDLE -Start-> HID -> OUT -> (r<M-1: HID with r+1 | r=M-1: FIN) ; FIN -> IDLE (Done=1 that cycle).
//  Neuron with K inputs (HID: K=N, OUT: K=H) lasts K+2 cycles:
//    issue cycle 0: bias address (B k=0,col j / C k=0)
//    issue cycles 1..K: weight k plus operand (HID: A[r][k-1]; OUT: hidden reg k-1)
//    finalise cycle K+1: last product accumulated, result computed and registered
//  Data for issue t is consumed at t+1. Read enables are high only in issue cycles.
//  HID runs neurons j=0..H-1 back to back, re-reading row r of A per neuron. OUT starts the next cycle.
//  RES_write_en/address/data are registered outputs, valid the cycle after OUT finalise.
//    The next row's HID issue 0 runs in that same cycle.
//  Cycles per row = H*(N+2)+(H+2). Defaults: 22/row.
//    First issue the cycle after Start. Done = cycle after last RES_write_en (1409 cycles Start->Done).
//  Arithmetic: product = a*w (2*WIDTH signed).
//    acc (2*WIDTH+clog2(K+1) bits) starts at sign-extended bias <<< FRAC_BITS and sums products.
//    result = acc >>> FRAC_BITS (floor), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//    Hidden neurons only: ReLU if HIDDEN_RELU. Hidden regs hold WIDTH-bit post-activation values.
//  Start while Busy or in FIN: ignored, no restart. Start coincident with rst deassert edge: ignored.
//  Address counters never wrap: row r stops at M-1. Addresses hold last value when enables are low.
// TESTING
//  T1 defaults, all A=0x10 (1.0), B weights 0x10 and bias 0, C weights 0x08 and bias 0.
//     -> hidden 7.0 each; RES[r]=0x70 (7.0) for all 64 rows; Done at cycle 1409; exactly 64 RES strobes.
//  T2 as T1 but C weights 0x10 -> sum 14.0 saturates: every RES=0x7F.
//  T3 B weights 0xF0 (-1.0), C bias 0x18 (1.5), HIDDEN_RELU=1 -> hidden 0, RES=0x18.
//     Same stimulus with HIDDEN_RELU=0 -> RES = sat(1.5-14.0)=0x80.
//  T4 reference model with random signed A/B/C, also H=4,N=3,M=5 build
//     -> RES matches bit-exact (floor+saturate); per-row spacing H*(N+2)+H+2 cycles.
//  T5 rst asserted at cycle 500 of a run -> outputs 0 that cycle, no Done.
//     Fresh Start then completes T1 result with correct timing.
//  T6 extra Start pulses at cycles 3 and 700 of a run -> ignored; single Done, results unchanged.

Source files
------------

// File: rtl/mlp_inference_engine.sv
// Two-layer perceptron engine: H hidden neurons over A/B, one output neuron over hidden/C.
// Serial schedule, one MAC per cycle, one synchronous read port per weight/data memory.
module mlp_inference_engine #(
  parameter int WIDTH          = 8,
  parameter int FRAC_BITS      = 4,
  parameter int M              = 64,
  parameter int N              = 7,
  parameter int H              = 2,
  parameter int HIDDEN_RELU    = 1,
  parameter int A_DEPTH_BITS   = 9,
  parameter int B_DEPTH_BITS   = 4,
  parameter int C_DEPTH_BITS   = 2,
  parameter int RES_DEPTH_BITS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  output logic                      Done,
  output logic                      Busy,
  output logic                      A_read_en,
  output logic [A_DEPTH_BITS-1:0]   A_read_address,
  input  logic [WIDTH-1:0]          A_read_data_out,
  output logic                      B_read_en,
  output logic [B_DEPTH_BITS-1:0]   B_read_address,
  input  logic [WIDTH-1:0]          B_read_data_out,
  output logic                      C_read_en,
  output logic [C_DEPTH_BITS-1:0]   C_read_address,
  input  logic [WIDTH-1:0]          C_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_DEPTH_BITS-1:0] RES_write_address,
  output logic [WIDTH-1:0]          RES_write_data_in
);

  localparam int KMAX  = (N > H) ? N : H;
  localparam int KW    = $clog2(KMAX + 2);
  localparam int JW    = $clog2(H + 1);
  localparam int RW    = $clog2(M + 1);
  localparam int ACC_W = 2 * WIDTH + $clog2(KMAX + 1);
  localparam int MAXV  = 2 ** (WIDTH - 1) - 1;
  localparam int MINV  = -(2 ** (WIDTH - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(MAXV);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(MINV);

  typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_FIN} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic [RW-1:0] r_q, r_d;
  logic          armed_q;

  logic                      a_en_q, a_en_d, b_en_q, b_en_d, c_en_q, c_en_d;
  logic [A_DEPTH_BITS-1:0]   a_addr_q, a_addr_d;
  logic [B_DEPTH_BITS-1:0]   b_addr_q, b_addr_d;
  logic [C_DEPTH_BITS-1:0]   c_addr_q, c_addr_d;
  logic                      done_q, busy_q, res_we_q;
  logic [RES_DEPTH_BITS-1:0] res_addr_q;
  logic [WIDTH-1:0]          res_data_q;

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [WIDTH-1:0]   hid_q [H];

  logic signed [WIDTH-1:0]   wdata, opnd, sat_val, act_val;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   bias_ext, sum, shifted;
  logic                      fin_hid, fin_out;

  assign fin_hid = (state_q == S_HID) && (k_q == KW'(N + 1));
  assign fin_out = (state_q == S_OUT) && (k_q == KW'(H + 1));

  // Sequencer next state: neuron phase k, neuron j, row r.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: if (Start && armed_q) begin
        state_d = S_HID;
        k_d     = '0;
        j_d     = '0;
        r_d     = '0;
      end
      S_HID: if (fin_hid) begin
        k_d = '0;
        if (j_q == JW'(H - 1)) begin
          state_d = S_OUT;
          j_d     = '0;
        end else begin
          j_d = j_q + JW'(1);
        end
      end else begin
        k_d = k_q + KW'(1);
      end
      S_OUT: if (fin_out) begin
        k_d = '0;
        if (r_q == RW'(M - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_HID;
          r_d     = r_q + RW'(1);
        end
      end else begin
        k_d = k_q + KW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read ports are registered, so they are derived from the upcoming phase; addresses hold when idle.
  always_comb begin
    a_en_d   = 1'b0;
    b_en_d   = 1'b0;
    c_en_d   = 1'b0;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    if (state_d == S_HID && k_d <= KW'(N)) begin
      b_en_d   = 1'b1;
      b_addr_d = B_DEPTH_BITS'(k_d * H + j_d);
      if (k_d != '0) begin
        a_en_d   = 1'b1;
        a_addr_d = A_DEPTH_BITS'(r_d * N + k_d - 1);
      end
    end
    if (state_d == S_OUT && k_d <= KW'(H)) begin
      c_en_d   = 1'b1;
      c_addr_d = C_DEPTH_BITS'(k_d);
    end
  end

  // MAC datapath: operand/weight selection, accumulate, floor shift, saturate, activation.
  always_comb begin
    wdata = (state_q == S_HID) ? B_read_data_out : C_read_data_out;
    opnd  = A_read_data_out;
    if (state_q == S_OUT) begin
      for (int unsigned i = 0; i < H; i++) begin
        if (k_q == KW'(i + 2)) opnd = hid_q[i];
      end
    end
    prod     = opnd * wdata;
    bias_ext = ACC_W'(wdata);
    sum      = acc_q + ACC_W'(prod);
    shifted  = sum >>> FRAC_BITS;
    if (shifted > SAT_HI)      sat_val = WIDTH'(MAXV);
    else if (shifted < SAT_LO) sat_val = WIDTH'(MINV);
    else                       sat_val = shifted[WIDTH-1:0];
    act_val = (HIDDEN_RELU != 0 && sat_val[WIDTH-1]) ? '0 : sat_val;
  end

  // FSM, registered outputs, accumulator and hidden registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      j_q        <= '0;
      r_q        <= '0;
      armed_q    <= 1'b0;
      a_en_q     <= 1'b0;
      b_en_q     <= 1'b0;
      c_en_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
      acc_q      <= '0;
      for (int unsigned i = 0; i < H; i++) hid_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      r_q      <= r_d;
      // Blocks a Start sampled on the first edge after reset release.
      armed_q  <= 1'b1;
      a_en_q   <= a_en_d;
      b_en_q   <= b_en_d;
      c_en_q   <= c_en_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      done_q   <= (state_q == S_FIN);
      busy_q   <= (state_d != S_IDLE);
      res_we_q <= fin_out;
      if (fin_out) begin
        res_addr_q <= RES_DEPTH_BITS'(r_q);
        res_data_q <= sat_val;
      end
      if ((state_q == S_HID || state_q == S_OUT) && k_q != '0) begin
        acc_q <= (k_q == KW'(1)) ? (bias_ext <<< FRAC_BITS) : sum;
      end
      if (fin_hid) begin
        for (int unsigned i = 0; i < H; i++) begin
          if (j_q == JW'(i)) hid_q[i] <= act_val;
        end
      end
    end
  end

  assign Done              = done_q;
  assign Busy              = busy_q;
  assign A_read_en         = a_en_q;
  assign A_read_address    = a_addr_q;
  assign B_read_en         = b_en_q;
  assign B_read_address    = b_addr_q;
  assign C_read_en         = c_en_q;
  assign C_read_address    = c_addr_q;
  assign RES_write_en      = res_we_q;
  assign RES_write_address = res_addr_q;
  assign RES_write_data_in = res_data_q;

endmodule

// File: tb/tb_mlp_inference_engine.sv
// Scoreboard bench for mlp_inference_engine: default build (ReLU and identity) plus an H=4,N=3,M=5 build.
module tb_mlp_inference_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  int t0_g  = 0;
  int per_g = 22;

  typedef struct {int addr; int data;} exp_t;
  exp_t sbq[$];

  logic signed [7:0] amem [512];
  logic signed [7:0] bmem [16];
  logic signed [7:0] cmem [8];

  logic start0, start1, start2;
  logic done0, busy0, aen0, ben0, cen0, we0;
  logic done1, busy1, aen1, ben1, cen1, we1;
  logic done2, busy2, aen2, ben2, cen2, we2;
  logic [8:0] aaddr0, aaddr1;
  logic [3:0] aaddr2;
  logic [3:0] baddr0, baddr1, baddr2;
  logic [1:0] caddr0, caddr1;
  logic [2:0] caddr2;
  logic [5:0] waddr0, waddr1;
  logic [2:0] waddr2;
  logic [7:0] adata0, bdata0, cdata0, wdata0;
  logic [7:0] adata1, bdata1, cdata1, wdata1;
  logic [7:0] adata2, bdata2, cdata2, wdata2;

  mlp_inference_engine dut0 (
    .clk(clk), .rst(rst), .Start(start0), .Done(done0), .Busy(busy0),
    .A_read_en(aen0), .A_read_address(aaddr0), .A_read_data_out(adata0),
    .B_read_en(ben0), .B_read_address(baddr0), .B_read_data_out(bdata0),
    .C_read_en(cen0), .C_read_address(caddr0), .C_read_data_out(cdata0),
    .RES_write_en(we0), .RES_write_address(waddr0), .RES_write_data_in(wdata0));

  mlp_inference_engine #(.HIDDEN_RELU(0)) dut1 (
    .clk(clk), .rst(rst), .Start(start1), .Done(done1), .Busy(busy1),
    .A_read_en(aen1), .A_read_address(aaddr1), .A_read_data_out(adata1),
    .B_read_en(ben1), .B_read_address(baddr1), .B_read_data_out(bdata1),
    .C_read_en(cen1), .C_read_address(caddr1), .C_read_data_out(cdata1),
    .RES_write_en(we1), .RES_write_address(waddr1), .RES_write_data_in(wdata1));

  mlp_inference_engine #(.M(5), .N(3), .H(4), .A_DEPTH_BITS(4), .B_DEPTH_BITS(4),
                         .C_DEPTH_BITS(3), .RES_DEPTH_BITS(3)) dut2 (
    .clk(clk), .rst(rst), .Start(start2), .Done(done2), .Busy(busy2),
    .A_read_en(aen2), .A_read_address(aaddr2), .A_read_data_out(adata2),
    .B_read_en(ben2), .B_read_address(baddr2), .B_read_data_out(bdata2),
    .C_read_en(cen2), .C_read_address(caddr2), .C_read_data_out(cdata2),
    .RES_write_en(we2), .RES_write_address(waddr2), .RES_write_data_in(wdata2));

  // Synchronous one-cycle-latency memories
  always @(posedge clk) begin
    if (aen0) adata0 <= amem[aaddr0];
    if (ben0) bdata0 <= bmem[baddr0];
    if (cen0) cdata0 <= cmem[caddr0];
    if (aen1) adata1 <= amem[aaddr1];
    if (ben1) bdata1 <= bmem[baddr1];
    if (cen1) cdata1 <= cmem[caddr1];
    if (aen2) adata2 <= amem[aaddr2];
    if (ben2) bdata2 <= bmem[baddr2];
    if (cen2) cdata2 <= cmem[caddr2];
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic score(input int a, input int d);
    exp_t e;
    n_wr++;
    check_eq("sb_nonempty", int'(sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check_eq("res_addr", a, e.addr);
      check_eq("res_data", d, e.data);
      check_eq("wr_cycle", cyc - t0_g, per_g * (a + 1));
    end
  endtask

  always @(negedge clk) begin
    if (we0) score(int'(waddr0), int'(wdata0));
    if (we1) score(int'(waddr1), int'(wdata1));
    if (we2) score(int'(waddr2), int'(wdata2));
  end

  function automatic longint sat8(input longint v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int model(input int r, input int n, input int h, input bit relu);
    longint acc, v;
    longint hid [8];
    for (int j = 0; j < h; j++) begin
      acc = longint'(bmem[j]) * 16;
      for (int k = 1; k <= n; k++)
        acc += longint'(amem[r*n+k-1]) * longint'(bmem[k*h+j]);
      v = sat8(acc >>> 4);
      if (relu && v < 0) v = 0;
      hid[j] = v;
    end
    acc = longint'(cmem[0]) * 16;
    for (int j = 0; j < h; j++) acc += hid[j] * longint'(cmem[j+1]);
    v = sat8(acc >>> 4);
    return int'(v) & 255;
  endfunction

  task automatic fill_const(input int av, input int bw, input int bb, input int cw, input int cb, input int h);
    for (int i = 0; i < 512; i++) amem[i] = 8'(av);
    for (int i = 0; i < 16; i++)  bmem[i] = 8'((i < h) ? bb : bw);
    for (int i = 0; i < 8; i++)   cmem[i] = 8'((i == 0) ? cb : cw);
  endtask

  task automatic fill_rand(input int lim);
    for (int i = 0; i < 512; i++) amem[i] = 8'(int'($urandom_range(0, 2*lim-1)) - lim);
    for (int i = 0; i < 16; i++)  bmem[i] = 8'(int'($urandom_range(0, 2*lim-1)) - lim);
    for (int i = 0; i < 8; i++)   cmem[i] = 8'(int'($urandom_range(0, 2*lim-1)) - lim);
  endtask

  task automatic set_start(input int sel, input bit v);
    case (sel)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic int get_done(input int sel);
    return (sel == 0) ? int'(done0) : (sel == 1) ? int'(done1) : int'(done2);
  endfunction

  function automatic int get_busy(input int sel);
    return (sel == 0) ? int'(busy0) : (sel == 1) ? int'(busy1) : int'(busy2);
  endfunction

  task automatic check_dut0_reset(input string tag);
    check_eq({tag, "_ctrl"}, int'({busy0, done0, aen0, ben0, cen0, we0}), 0);
    check_eq({tag, "_addr"}, int'({aaddr0, baddr0, caddr0, waddr0}), 0);
    check_eq({tag, "_wdata"}, int'(wdata0), 0);
  endtask

  // expv < 0 selects the reference model; abort_at > 0 asserts rst that many cycles into the run
  task automatic run(input int sel, input int mrows, input int per, input int n, input int h,
                     input bit relu, input int expv, input int abort_at, input bit extra);
    int w0, dcnt;
    bit got;
    exp_t e;
    for (int r = 0; r < mrows; r++) begin
      e.addr = r;
      e.data = (expv < 0) ? model(r, n, h, relu) : expv;
      sbq.push_back(e);
    end
    w0 = n_wr; dcnt = 0; got = 0;
    @(negedge clk); set_start(sel, 1'b1); t0_g = cyc + 1; per_g = per;
    @(negedge clk); set_start(sel, 1'b0);
    check_eq("busy_after_start", get_busy(sel), 1);
    while (!got && (cyc - t0_g) < mrows * per + 50) begin
      @(negedge clk);
      set_start(sel, extra && ((cyc - t0_g) == 3 || (cyc - t0_g) == 700));
      if (abort_at > 0 && (cyc - t0_g) == abort_at) begin
        rst = 1'b1;
        #1;
        check_dut0_reset("abort");
        repeat (5) @(negedge clk) dcnt += get_done(sel);
        check_eq("abort_no_done", dcnt, 0);
        sbq.delete();
        return;
      end
      if (get_done(sel) != 0) begin
        got = 1;
        check_eq("done_cycle", cyc - t0_g, mrows * per + 1);
        check_eq("busy_at_done", get_busy(sel), 0);
      end
    end
    check_eq("done_seen", int'(got), 1);
    repeat (40) @(negedge clk) dcnt += get_done(sel);
    check_eq("single_done", dcnt, 0);
    check_eq("strobes", n_wr - w0, mrows);
    check_eq("sb_empty", int'(sbq.size()), 0);
    sbq.delete();
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    fill_const(16, 16, 0, 8, 0, 2);
    repeat (3) @(negedge clk);
    check_dut0_reset("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // T1: hidden 7.0, output 7.0
    run(0, 64, 22, 7, 2, 1'b1, 'h70, 0, 1'b0);
    // T2: output 14.0 saturates
    fill_const(16, 16, 0, 16, 0, 2);
    run(0, 64, 22, 7, 2, 1'b1, 'h7F, 0, 1'b0);
    // T3: negative hidden, ReLU vs identity
    fill_const(16, -16, 0, 16, 24, 2);
    run(0, 64, 22, 7, 2, 1'b1, 'h18, 0, 1'b0);
    run(1, 64, 22, 7, 2, 1'b0, 'h80, 0, 1'b0);
    // T4: random signed data, full and reduced range, both builds
    for (int rnd = 0; rnd < 2; rnd++) begin
      fill_rand((rnd == 0) ? 128 : 24);
      run(0, 64, 22, 7, 2, 1'b1, -1, 0, 1'b0);
      run(1, 64, 22, 7, 2, 1'b0, -1, 0, 1'b0);
      run(2, 5, 26, 3, 4, 1'b1, -1, 0, 1'b0);
    end
    // T5: abort at cycle 500, Start coincident with reset release ignored, then a clean run
    fill_const(16, 16, 0, 8, 0, 2);
    run(0, 64, 22, 7, 2, 1'b1, 'h70, 500, 1'b0);
    @(negedge clk); rst = 1'b0; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    dcnt = 0;
    repeat (10) @(negedge clk) dcnt += int'(busy0) + int'(done0);
    check_eq("start_at_rst_release", dcnt, 0);
    run(0, 64, 22, 7, 2, 1'b1, 'h70, 0, 1'b0);
    // T6: extra Start pulses during the run
    run(0, 64, 22, 7, 2, 1'b1, 'h70, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
